// File: rtl/rv32_pkg.sv
// Shared rv32imc core definitions: halfword width, PC type and the
// compressed-encoding test used by the fetch/decode path.
package rv32_pkg;
  localparam int HALFWORD_W = 16;

  typedef logic [31:0] pc_t;

  function automatic logic is_compressed(input logic [1:0] lsb);
    return lsb != 2'b11;
  endfunction
endpackage

// File: rtl/rv32_mod_instruction_aligner.sv
// Fetch-side aligner: buffers word fetches as halfwords and emits one
// 16-bit or 32-bit instruction per handshake with its PC.
module rv32_mod_instruction_aligner
  import rv32_pkg::*;
#(
  parameter pc_t RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_is_compressed
);

  logic [HALFWORD_W-1:0] hw_reg [4];
  logic [HALFWORD_W-1:0] hw_shift [4];
  logic [HALFWORD_W-1:0] hw_next [4];
  logic [2:0]            count_reg;
  logic [2:0]            count_next;
  pc_t                   head_pc_reg;
  logic                  drop_low_reg;

  logic       head_c;
  logic       consume;
  logic       accept;
  logic [2:0] consumed;
  logic [2:0] appended;
  logic [2:0] base;

  assign head_c = is_compressed(hw_reg[0][1:0]);

  always_comb begin
    instr_valid         = 1'b0;
    instruction         = 32'h0;
    instr_is_compressed = 1'b0;
    if (head_c) begin
      if (count_reg >= 3'd1) begin
        instr_valid         = 1'b1;
        instruction         = {16'h0, hw_reg[0]};
        instr_is_compressed = 1'b1;
      end
    end else if (count_reg >= 3'd2) begin
      instr_valid = 1'b1;
      instruction = {hw_reg[1], hw_reg[0]};
    end
  end

  assign instr_pc    = head_pc_reg;
  assign fetch_ready = (count_reg <= 3'd2) && !flush;
  assign consume     = instr_valid && instr_ready && !flush;
  assign accept      = fetch_valid && fetch_ready;
  assign consumed    = consume ? (head_c ? 3'd1 : 3'd2) : 3'd0;
  assign appended    = accept ? (drop_low_reg ? 3'd1 : 3'd2) : 3'd0;
  assign base        = count_reg - consumed;
  assign count_next  = count_reg - consumed + appended;

  // Drop the consumed halfwords first; new fetch data lands behind the survivors.
  for (genvar gi = 0; gi < 4; gi++) begin : g_shift
    logic [2:0] src;
    assign src          = 3'(gi) + consumed;
    assign hw_shift[gi] = (src < 3'd4) ? hw_reg[src[1:0]] : '0;
  end

  always_comb begin
    hw_next = hw_shift;
    if (accept) begin
      if (drop_low_reg) begin
        hw_next[base[1:0]] = fetch_data[31:16];
      end else begin
        hw_next[base[1:0]]         = fetch_data[15:0];
        hw_next[base[1:0] + 2'd1]  = fetch_data[31:16];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg    <= 3'd0;
      head_pc_reg  <= RESET_PC;
      drop_low_reg <= RESET_PC[1];
      for (int i = 0; i < 4; i++) hw_reg[i] <= '0;
    end else if (flush) begin
      count_reg    <= 3'd0;
      head_pc_reg  <= flush_pc & ~32'h1;
      drop_low_reg <= flush_pc[1];
    end else begin
      count_reg   <= count_next;
      hw_reg      <= hw_next;
      head_pc_reg <= head_pc_reg + {28'h0, consumed, 1'b0};
      if (accept) drop_low_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32_mod_instruction_aligner.sv
// Bench for the instruction aligner: directed vector table followed by a
// randomized stream checked against an address-level memory model.
module tb_rv32_mod_instruction_aligner;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_data = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_is_compressed;

  int total = 0;
  int bad   = 0;

  rv32_mod_instruction_aligner #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .flush(flush), .flush_pc(flush_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc),
    .instr_is_compressed(instr_is_compressed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [31:0] fd;
    logic        ir;
    logic        fl;
    logic [31:0] fpc;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] epc;
    logic        ec;
    logic        efr;
  } vec_t;

  function automatic vec_t mk(logic fv, logic [31:0] fd, logic ir, logic fl, logic [31:0] fpc,
                              logic ev, logic [31:0] ei, logic [31:0] epc, logic ec, logic efr);
    vec_t v;
    v.fv = fv; v.fd = fd; v.ir = ir; v.fl = fl; v.fpc = fpc;
    v.ev = ev; v.ei = ei; v.epc = epc; v.ec = ec; v.efr = efr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  logic [15:0] mem [64];

  function automatic logic [15:0] mh(input logic [31:0] a);
    return mem[a[6:1]];
  endfunction

  vec_t vecs [30];

  initial begin
    logic [31:0] fetch_addr, exp_pc, diff, ei;
    logic [15:0] eh;
    logic        ec, ev, efr, fv, ir, fl, acc, cons;
    logic [31:0] fpc;
    int          avail, len, n_cons;

    // inputs: fv fd ir fl fpc | outputs seen before the edge: valid instr pc comp fetch_ready
    vecs[0]  = mk(1, 32'h00A00093, 1, 0, 0,         0, 32'h0,        32'h000, 0, 1);
    vecs[1]  = mk(1, 32'h00B00113, 1, 0, 0,         1, 32'h00A00093, 32'h000, 0, 1);
    vecs[2]  = mk(0, 32'h0,        1, 0, 0,         1, 32'h00B00113, 32'h004, 0, 1);
    vecs[3]  = mk(1, 32'hDEADBEEF, 1, 1, 32'h0,     0, 32'h0,        32'h008, 0, 0);
    vecs[4]  = mk(1, 32'h45854505, 1, 0, 0,         0, 32'h0,        32'h000, 0, 1);
    vecs[5]  = mk(0, 32'h0,        1, 0, 0,         1, 32'h00004505, 32'h000, 1, 1);
    vecs[6]  = mk(0, 32'h0,        1, 0, 0,         1, 32'h00004585, 32'h002, 1, 1);
    vecs[7]  = mk(0, 32'h0,        1, 1, 32'h0,     0, 32'h0,        32'h004, 0, 0);
    vecs[8]  = mk(1, 32'h00934505, 1, 0, 0,         0, 32'h0,        32'h000, 0, 1);
    vecs[9]  = mk(1, 32'h451100A0, 1, 0, 0,         1, 32'h00004505, 32'h000, 1, 1);
    vecs[10] = mk(0, 32'h0,        1, 0, 0,         1, 32'h00A00093, 32'h002, 0, 0);
    vecs[11] = mk(0, 32'h0,        1, 0, 0,         1, 32'h00004511, 32'h006, 1, 1);
    vecs[12] = mk(0, 32'h0,        1, 1, 32'h0,     0, 32'h0,        32'h008, 0, 0);
    vecs[13] = mk(1, 32'h00A00093, 0, 0, 0,         0, 32'h0,        32'h000, 0, 1);
    vecs[14] = mk(1, 32'h00B00113, 0, 0, 0,         1, 32'h00A00093, 32'h000, 0, 1);
    vecs[15] = mk(0, 32'h0,        0, 0, 0,         1, 32'h00A00093, 32'h000, 0, 0);
    vecs[16] = mk(1, 32'h12345678, 0, 0, 0,         1, 32'h00A00093, 32'h000, 0, 0);
    vecs[17] = mk(0, 32'h0,        1, 0, 0,         1, 32'h00A00093, 32'h000, 0, 0);
    vecs[18] = mk(1, 32'h45854505, 1, 0, 0,         1, 32'h00B00113, 32'h004, 0, 1);
    vecs[19] = mk(1, 32'h45854505, 1, 0, 0,         1, 32'h00004505, 32'h008, 1, 1);
    vecs[20] = mk(1, 32'h11111111, 1, 1, 32'h102,   1, 32'h00004585, 32'h00A, 1, 0);
    vecs[21] = mk(1, 32'h4505FFFF, 1, 0, 0,         0, 32'h0,        32'h102, 0, 1);
    vecs[22] = mk(0, 32'h0,        1, 0, 0,         1, 32'h00004505, 32'h102, 1, 1);
    vecs[23] = mk(0, 32'h0,        1, 0, 0,         0, 32'h0,        32'h104, 0, 1);
    vecs[24] = mk(0, 32'h0,        1, 1, 32'h200,   0, 32'h0,        32'h104, 0, 0);
    vecs[25] = mk(1, 32'h0,        1, 1, 32'h303,   0, 32'h0,        32'h200, 0, 0);
    vecs[26] = mk(1, 32'h00130013, 1, 0, 0,         0, 32'h0,        32'h302, 0, 1);
    vecs[27] = mk(1, 32'h00000093, 1, 0, 0,         0, 32'h0,        32'h302, 0, 1);
    vecs[28] = mk(0, 32'h0,        1, 0, 0,         1, 32'h00930013, 32'h302, 0, 0);
    vecs[29] = mk(0, 32'h0,        1, 0, 0,         1, 32'h00000000, 32'h306, 1, 1);

    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_valid", {31'h0, instr_valid}, 32'h0);
    chk("reset_instr", instruction, 32'h0);
    chk("reset_pc", instr_pc, 32'h0);
    chk("reset_comp", {31'h0, instr_is_compressed}, 32'h0);
    chk("reset_fready", {31'h0, fetch_ready}, 32'h1);

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      fetch_valid = vecs[i].fv; fetch_data = vecs[i].fd; instr_ready = vecs[i].ir;
      flush = vecs[i].fl; flush_pc = vecs[i].fpc;
      #1;
      $display("vec %0d: valid=%0b instr=%h pc=%h comp=%0b fready=%0b", i,
               instr_valid, instruction, instr_pc, instr_is_compressed, fetch_ready);
      chk($sformatf("vec%0d_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].ev});
      chk($sformatf("vec%0d_instr", i), instruction, vecs[i].ei);
      chk($sformatf("vec%0d_pc", i), instr_pc, vecs[i].epc);
      chk($sformatf("vec%0d_comp", i), {31'h0, instr_is_compressed}, {31'h0, vecs[i].ec});
      chk($sformatf("vec%0d_fready", i), {31'h0, fetch_ready}, {31'h0, vecs[i].efr});
    end

    // Random phase: model tracks the next fetch address and the next expected PC.
    @(negedge clk);
    fpc = $urandom;
    fetch_valid = 1'b0; instr_ready = 1'b0; flush = 1'b1; flush_pc = fpc;
    fetch_addr = fpc & ~32'h3;
    exp_pc     = fpc & ~32'h1;
    n_cons     = 0;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      fl  = ($urandom_range(0, 31) == 0);
      fpc = $urandom;
      fv  = ($urandom_range(0, 3) != 0);
      ir  = ($urandom_range(0, 3) != 0);
      fetch_valid = fv; instr_ready = ir; flush = fl; flush_pc = fpc;
      fetch_data = {mh(fetch_addr + 32'd2), mh(fetch_addr)};
      #1;
      diff  = fetch_addr - exp_pc;
      avail = int'($signed(diff)) / 2;
      eh    = mh(exp_pc);
      ec    = (eh[1:0] != 2'b11);
      len   = ec ? 1 : 2;
      ei    = ec ? {16'h0, eh} : {mh(exp_pc + 32'd2), eh};
      ev    = (avail >= len);
      efr   = (avail <= 2) && !fl;
      chk("rnd_valid", {31'h0, instr_valid}, {31'h0, ev});
      chk("rnd_fready", {31'h0, fetch_ready}, {31'h0, efr});
      chk("rnd_pc", instr_pc, exp_pc);
      chk("rnd_instr", instruction, ev ? ei : 32'h0);
      chk("rnd_comp", {31'h0, instr_is_compressed}, {31'h0, ev & ec});
      acc  = fv && efr;
      cons = ev && ir && !fl;
      if (cons) begin
        n_cons++;
        $display("rnd %0d: instr=%h pc=%h comp=%0b", i, ei, exp_pc, ec);
      end
      if (fl) begin
        fetch_addr = fpc & ~32'h3;
        exp_pc     = fpc & ~32'h1;
      end else begin
        if (acc) fetch_addr = fetch_addr + 32'd4;
        if (cons) exp_pc = exp_pc + 32'(2 * len);
      end
    end
    chk("rnd_progress", {31'h0, n_cons > 500}, 32'h1);

    // Reset in the middle of traffic with handshakes pending.
    @(negedge clk);
    fetch_valid = 1'b1; instr_ready = 1'b1; flush = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'h0, instr_valid}, 32'h0);
    chk("midrst_pc", instr_pc, 32'h0);
    chk("midrst_fready", {31'h0, fetch_ready}, 32'h1);
    chk("midrst_instr", instruction, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    fetch_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv32_mod_instruction_aligner.md
Name: rv32_mod_instruction_aligner

Overview:
- Fetch-side stage directly upstream of the instruction decoder (and its immediate decoder) in the rv32imc core.
- Accepts word-aligned 32-bit fetch words and buffers them as halfwords.
- Emits one aligned instruction per handshake: either a 16-bit compressed instruction (zero-extended) or a 32-bit instruction, which may straddle two fetch words.
- Also tracks the PC of each emitted instruction and handles redirects (flush), including redirects to halfword-aligned targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC assigned to the first instruction after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- fetch_valid  input  1  fetch_data is valid this cycle.
- fetch_ready  output  1  aligner accepts fetch_data this cycle.
- fetch_data  input  32  fetch word; bits [15:0] are the lower-addressed halfword.
- flush  input  1  redirect: discard all buffered state.
- flush_pc  input  32  redirect target; bit 0 ignored, bit 1 may be set.
- instr_valid  output  1  instruction/instr_pc/instr_is_compressed are valid.
- instr_ready  input  1  consumer takes the instruction this cycle.
- instruction  output  32  aligned instruction; compressed as {16'h0, hw}.
- instr_pc  output  32  address of instruction.
- instr_is_compressed  output  1  instruction[1:0] != 2'b11.

Behaviour:
- Storage: 4 halfword slots (hw0 = oldest), count 0..4, head_pc register, drop_low flag.
- Reset values:
  - count = 0, head_pc = RESET_PC, drop_low = RESET_PC[1].
  - Outputs instr_valid = 0, fetch_ready = 1, instruction = 0, instr_pc = RESET_PC, instr_is_compressed = 0.
- fetch_ready = (count <= 2) && !flush. Combinational from registered count only; not from instr_ready.
- Accept: fetch_valid && fetch_ready.
  - drop_low = 0: append both halfwords, count += 2.
  - drop_low = 1: append only fetch_data[31:16], count += 1, clear drop_low.
- Output decode is combinational from the registers:
  - hw0[1:0] != 2'b11 (compressed): instr_valid = (count >= 1), instruction = {16'h0, hw0}.
  - Otherwise: instr_valid = (count >= 2), instruction = {hw1, hw0}.
  - instr_pc = head_pc.
  - When instr_valid = 0: instruction = 0, instr_is_compressed = 0.
- Consume: instr_valid && instr_ready.
  - Shift out 1 (compressed) or 2 halfwords.
  - head_pc += 2 or 4 (mod 2^32, wraps silently).
- Simultaneous accept and consume in the same cycle: shift first, then append. count_next = count - consumed + appended.
- Latency: word accepted in cycle N → instruction visible from cycle N+1.
  - For a straddling 32-bit instruction, visible the cycle after the second word is accepted.
  - Outputs must hold stable while instr_valid && !instr_ready.
- Throughput: sustained 1 instruction/cycle for all-32-bit aligned streams. Compressed streams are bounded by fetch bandwidth.
- flush has highest priority. In the flush cycle:
  - fetch_ready = 0; no accept.
  - A consume does not advance state, even if instr_ready is high.
  - Next cycle: count = 0, head_pc = {flush_pc[31:1], 1'b0}, drop_low = flush_pc[1].
- Boundaries:
  - count = 4: fetch_ready = 0.
  - count = 1 holding the low half of a 32-bit instruction: instr_valid = 0 until the next word arrives.
  - Back-to-back flushes: the last one wins.
  - rst asserted mid-operation: immediately returns to reset state, regardless of pending handshakes.
- No stored-illegal detection; 32-bit encodings with [4:2] = 3'b111 are passed through unchanged.

Decomposition:
- Shared package rv32_pkg (extend if present) holds:
  - localparam HALFWORD_W = 16.
  - function is_compressed(logic [1:0] lsb).
  - typedef logic [31:0] pc_t.
- No sub-module: the halfword buffer stays inline. The compressed-to-32-bit expander is a separate downstream block and is out of scope here.

Test Plan:
- Reset, then words 32'h00A00093 and 32'h00B00113 → two 32-bit instructions at pc 0x0 and 0x4, instr_is_compressed = 0, each valid one cycle after its accept.
- Word 32'h45854505 (c.li a0,1 / c.li a1,1) → instructions 32'h00004505 @0x0, then 32'h00004585 @0x2, both compressed.
- Straddle: words 32'h00934505 then 32'h451100A0 → 32'h00004505 @0x0, then 32'h00A00093 @0x2 (spans both words), then 32'h00004511 @0x6.
- Back-pressure: instr_ready = 0 while streaming 32-bit words → count saturates at 4, fetch_ready = 0, outputs stable. Release → resumes with no loss or duplication.
- Flush to 0x0000_0102 while count = 3 → buffer cleared; next word 32'h4505FFFF yields 32'h00004505 @0x102; the low halfword is discarded.
- Flush asserted in the same cycle as instr_valid && instr_ready && fetch_valid → neither handshake takes effect, and the first instruction after the flush is at flush_pc.
